// File: rtl/max6675_multi_reader.sv
// Round-robin MAX6675 thermocouple scanner: one SPI mode-0 receive engine on a shared SCK/MISO, per-channel CS.
// Optional per-channel last-good temperature hold on faulted frames: define MAX6675_FAULT_HOLD_EN.
module max6675_multi_reader #(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned CLKS_PER_HALF_BIT  = 13,
    parameter int unsigned CS_SETUP_CLKS      = 10,
    parameter int unsigned SAMPLE_PERIOD_CLKS = 22000000,
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    output logic              o_spi_clk,
    output logic [NUM_CH-1:0] o_cs_n,
    input  logic              i_spi_miso,
    output logic              o_dv,
    output logic [CH_W-1:0]   o_ch,
    output logic [11:0]       o_temp,
    output logic              o_open,
    output logic              o_bus_err,
    output logic [15:0]       o_frame,
    output logic              o_busy
);

    localparam int unsigned CNT_MAX = (CLKS_PER_HALF_BIT > CS_SETUP_CLKS) ? CLKS_PER_HALF_BIT : CS_SETUP_CLKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned TMR_W   = (SAMPLE_PERIOD_CLKS > 1) ? $clog2(SAMPLE_PERIOD_CLKS) : 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(SAMPLE_PERIOD_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CS_SETUP_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, SHIFT, CS_HOLD, PUBLISH, NEXT, WAIT_PERIOD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] timer;
    logic [CH_W-1:0]  ch;
    logic [3:0]       bit_idx;
    logic [15:0]      shreg;

`ifdef MAX6675_FAULT_HOLD_EN
    logic [11:0] last_good [NUM_CH];
    logic        faulted;
    assign faulted = shreg[15] | shreg[2] | shreg[1];
`endif

    // All CS high except the selected channel.
    function automatic logic [NUM_CH-1:0] cs_sel(input logic [CH_W-1:0] c);
        cs_sel = ~(NUM_CH'(1) << c);
    endfunction

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            timer     <= '0;
            ch        <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            o_spi_clk <= 1'b0;
            o_cs_n    <= '1;
            o_dv      <= 1'b0;
            o_ch      <= '0;
            o_temp    <= '0;
            o_open    <= 1'b0;
            o_bus_err <= 1'b0;
            o_frame   <= '0;
            o_busy    <= 1'b0;
`ifdef MAX6675_FAULT_HOLD_EN
            for (int i = 0; i < int'(NUM_CH); i++) last_good[i] <= '0;
`endif
        end else begin
            o_dv <= 1'b0;
            // Sweep timer saturates so an overlong sweep restarts right away.
            if (timer != TMR_END) timer <= timer + TMR_W'(1);

            case (state)
                IDLE: begin
                    if (i_enable) begin
                        timer  <= '0;
                        ch     <= '0;
                        cnt    <= '0;
                        o_cs_n <= cs_sel('0);
                        o_busy <= 1'b1;
                        state  <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (cnt == SETUP_END) begin
                        cnt       <= '0;
                        bit_idx   <= '0;
                        o_spi_clk <= 1'b1;
                        shreg     <= {shreg[14:0], i_spi_miso};
                        state     <= SHIFT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    // MISO is captured on the cycle SCK is driven high.
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        if (o_spi_clk) begin
                            o_spi_clk <= 1'b0;
                        end else if (bit_idx == 4'd15) begin
                            o_cs_n <= '1;
                            state  <= CS_HOLD;
                        end else begin
                            o_spi_clk <= 1'b1;
                            shreg     <= {shreg[14:0], i_spi_miso};
                            bit_idx   <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CS_HOLD: begin
                    o_dv      <= 1'b1;
                    o_ch      <= ch;
                    o_frame   <= shreg;
                    o_open    <= shreg[2];
                    o_bus_err <= shreg[15] | shreg[1];
`ifdef MAX6675_FAULT_HOLD_EN
                    if (!faulted) begin
                        last_good[ch] <= shreg[14:3];
                        o_temp        <= shreg[14:3];
                    end else begin
                        o_temp <= last_good[ch];
                    end
`else
                    o_temp    <= shreg[14:3];
`endif
                    state <= PUBLISH;
                end
                PUBLISH: begin
                    o_busy <= 1'b0;
                    cnt    <= '0;
                    state  <= NEXT;
                end
                NEXT: begin
                    if (ch == LAST_CH) begin
                        ch    <= '0;
                        state <= WAIT_PERIOD;
                    end else if (cnt == SETUP_END) begin
                        cnt    <= '0;
                        ch     <= ch + CH_W'(1);
                        o_cs_n <= cs_sel(ch + CH_W'(1));
                        o_busy <= 1'b1;
                        state  <= CS_SETUP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_PERIOD: begin
                    if (timer == TMR_END) begin
                        if (i_enable) begin
                            timer  <= '0;
                            cnt    <= '0;
                            o_cs_n <= cs_sel('0);
                            o_busy <= 1'b1;
                            state  <= CS_SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max6675_multi_reader.sv
// Directed bench for max6675_multi_reader: four MAX6675 device models on a shared MISO, table-driven sweeps
// plus hand-written enable-drop and mid-frame reset sequences.
module tb_max6675_multi_reader;

    localparam int unsigned PERIOD = 5000;

`ifdef MAX6675_FAULT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        spi_clk;
    logic [3:0]  cs_n;
    logic        miso;
    logic        dv;
    logic [1:0]  ch;
    logic [11:0] temp;
    logic        open_tc;
    logic        bus_err;
    logic [15:0] frame;
    logic        busy;

    max6675_multi_reader #(
        .NUM_CH(4), .CLKS_PER_HALF_BIT(13), .CS_SETUP_CLKS(10), .SAMPLE_PERIOD_CLKS(PERIOD)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en), .o_spi_clk(spi_clk), .o_cs_n(cs_n),
        .i_spi_miso(miso), .o_dv(dv), .o_ch(ch), .o_temp(temp), .o_open(open_tc),
        .o_bus_err(bus_err), .o_frame(frame), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Device model: MSB presented on CS fall, next bit after every SCK falling edge.
    logic [15:0] words [4];
    logic        tie_high;
    logic [3:0]  bitpos;
    logic        prev_sck_m;
    logic [15:0] cur_word;
    logic [3:0]  bsel;

    always @(posedge clk) begin
        prev_sck_m <= spi_clk;
        if (&cs_n) bitpos <= 4'd0;
        else if (prev_sck_m && !spi_clk) bitpos <= bitpos + 4'd1;
    end

    always_comb begin
        cur_word = words[0];
        for (int i = 0; i < 4; i++) if (!cs_n[i]) cur_word = words[i];
        bsel = 4'd15 - bitpos;
        miso = 1'b0;
        if (tie_high) miso = 1'b1;
        else if (!(&cs_n)) miso = cur_word[bsel];
    end

    // Bus monitor: timing capture and protocol invariants.
    int   cyc = 0;
    int   dv_cnt = 0;
    int   cs_viol = 0;
    int   sck_viol = 0;
    int   sck_edges = 0;
    int   cs0_falls [$];
    int   rises [$];
    logic prev_cs0 = 1'b1;
    logic prev_sck = 1'b0;
    logic prev_all_hi = 1'b1;

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        dv_cnt      <= dv_cnt + (dv ? 1 : 0);
        prev_cs0    <= cs_n[0];
        prev_sck    <= spi_clk;
        prev_all_hi <= &cs_n;
        if (prev_cs0 && !cs_n[0]) cs0_falls.push_back(cyc);
        if ($countones(~cs_n) > 1) cs_viol <= cs_viol + 1;
        if (prev_all_hi && (&cs_n) && (spi_clk != prev_sck)) sck_viol <= sck_viol + 1;
        if (cs0_falls.size() == 1 && !cs_n[0] && spi_clk != prev_sck) begin
            sck_edges <= sck_edges + 1;
            if (spi_clk) rises.push_back(cyc);
        end
    end

    typedef struct {
        logic [15:0] word;
        logic        tie;
        logic [1:0]  ch;
        logic [11:0] temp;
        logic        open_tc;
        logic        err;
        logic [15:0] frame;
    } vec_t;

    vec_t tbl [12];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_dv(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (dv) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_cs_low(input int idx, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (!cs_n[idx]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int nf;
        int d0;

        // Sweep 0: nominal; sweep 1: ch2 open; sweep 2: MISO stuck high.
        tbl[0]  = '{16'h0320, 1'b0, 2'd0, 12'h064, 1'b0, 1'b0, 16'h0320};
        tbl[1]  = '{16'h0640, 1'b0, 2'd1, 12'h0C8, 1'b0, 1'b0, 16'h0640};
        tbl[2]  = '{16'h0960, 1'b0, 2'd2, 12'h12C, 1'b0, 1'b0, 16'h0960};
        tbl[3]  = '{16'h0C80, 1'b0, 2'd3, 12'h190, 1'b0, 1'b0, 16'h0C80};
        tbl[4]  = '{16'h0320, 1'b0, 2'd0, 12'h064, 1'b0, 1'b0, 16'h0320};
        tbl[5]  = '{16'h0640, 1'b0, 2'd1, 12'h0C8, 1'b0, 1'b0, 16'h0640};
        tbl[6]  = '{16'h0004, 1'b0, 2'd2, HOLD ? 12'h12C : 12'h000, 1'b1, 1'b0, 16'h0004};
        tbl[7]  = '{16'h0C80, 1'b0, 2'd3, 12'h190, 1'b0, 1'b0, 16'h0C80};
        tbl[8]  = '{16'h0000, 1'b1, 2'd0, HOLD ? 12'h064 : 12'hFFF, 1'b1, 1'b1, 16'hFFFF};
        tbl[9]  = '{16'h0000, 1'b1, 2'd1, HOLD ? 12'h0C8 : 12'hFFF, 1'b1, 1'b1, 16'hFFFF};
        tbl[10] = '{16'h0000, 1'b1, 2'd2, HOLD ? 12'h12C : 12'hFFF, 1'b1, 1'b1, 16'hFFFF};
        tbl[11] = '{16'h0000, 1'b1, 2'd3, HOLD ? 12'h190 : 12'hFFF, 1'b1, 1'b1, 16'hFFFF};

        rst_n = 1'b0;
        en = 1'b0;
        tie_high = 1'b0;
        for (int c = 0; c < 4; c++) words[c] = tbl[c].word;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'hF);
        check("rst_sck", 32'(spi_clk), 32'd0);
        check("rst_dv", 32'(dv), 32'd0);
        check("rst_ch", 32'(ch), 32'd0);
        check("rst_temp", 32'(temp), 32'd0);
        check("rst_flags", {30'd0, open_tc, bus_err}, 32'd0);
        check("rst_frame", 32'(frame), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 4; c++) begin
                wait_dv($sformatf("dv_s%0d_c%0d", s, c), ok);
                if (ok) begin
                    check($sformatf("ch_s%0d_c%0d", s, c), 32'(ch), 32'(tbl[s*4+c].ch));
                    check($sformatf("temp_s%0d_c%0d", s, c), 32'(temp), 32'(tbl[s*4+c].temp));
                    check($sformatf("open_s%0d_c%0d", s, c), 32'(open_tc), 32'(tbl[s*4+c].open_tc));
                    check($sformatf("err_s%0d_c%0d", s, c), 32'(bus_err), 32'(tbl[s*4+c].err));
                    check($sformatf("frame_s%0d_c%0d", s, c), 32'(frame), 32'(tbl[s*4+c].frame));
                    check($sformatf("busy_s%0d_c%0d", s, c), 32'(busy), 32'd1);
                end
            end
            if (s < 2) begin
                for (int c = 0; c < 4; c++) words[c] = tbl[(s+1)*4+c].word;
                tie_high = tbl[(s+1)*4].tie;
            end
        end

        // SCK timing on the very first frame and the sweep period.
        check("sck_edges", 32'(sck_edges), 32'd32);
        if (cs0_falls.size() >= 2 && rises.size() >= 2) begin
            check("first_rise", 32'(rises[0] - cs0_falls[0]), 32'd10);
            check("sck_period", 32'(rises[1] - rises[0]), 32'd26);
            check("sweep_period", 32'(cs0_falls[1] - cs0_falls[0]), 32'(PERIOD));
        end else begin
            check("timing_capture", 32'(rises.size()), 32'd16);
        end

        // Drop enable during channel 1's shift: remaining channels finish, then idle.
        tie_high = 1'b0;
        for (int c = 0; c < 4; c++) words[c] = tbl[c].word;
        wait_cs_low(1, "cs1_low");
        repeat (50) @(negedge clk);
        en = 1'b0;
        check("busy_shift", 32'(busy), 32'd1);
        for (int k = 1; k < 4; k++) begin
            wait_dv($sformatf("dv_drop_%0d", k), ok);
            if (ok) check($sformatf("ch_drop_%0d", k), 32'(ch), 32'(k));
        end
        nf = cs0_falls.size();
        repeat (6000) @(negedge clk);
        check("idle_cs_n", 32'(cs_n), 32'hF);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_no_restart", 32'(cs0_falls.size()), 32'(nf));

        // Reset during bit 7 of a shift, then restart from channel 0.
        en = 1'b1;
        wait_cs_low(0, "cs0_low_rst");
        repeat (197) @(negedge clk);
        check("sck_high_bit7", 32'(spi_clk), 32'd1);
        d0 = dv_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", 32'(cs_n), 32'hF);
        check("rst_mid_sck", 32'(spi_clk), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_no_dv", 32'(dv_cnt), 32'(d0));
        wait_dv("dv_after_rst", ok);
        if (ok) begin
            check("ch_after_rst", 32'(ch), 32'd0);
            check("temp_after_rst", 32'(temp), 32'h064);
        end

        check("one_cs_low", 32'(cs_viol), 32'd0);
        check("sck_only_with_cs", 32'(sck_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/max6675_multi_reader.md
Name: max6675_multi_reader

Overview:
Multi-channel MAX6675 thermocouple scanner with an integrated SPI-mode-0 receive engine and shared SCK/MISO. Each channel has its own CS. Channels are read round-robin once per programmable sample period. Each 16-bit frame is decoded into a 12-bit temperature plus fault flags and published through a one-cycle valid strobe to downstream logic (UART packer, register file).

Parameters:
NUM_CH, 4, number of thermocouple channels (1..16)
CLKS_PER_HALF_BIT, 13, i_clk cycles per SCK half-period (100 MHz -> ~3.8 MHz SCK)
CS_SETUP_CLKS, 10, cycles between CS falling and first SCK rise; also minimum CS-high time between frames
SAMPLE_PERIOD_CLKS, 22000000, cycles from the start of one sweep to the start of the next (220 ms at 100 MHz, the MAX6675 conversion time)
CH_W, max(1,clog2(NUM_CH)), channel index width (derived, not overridden)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  scan enable; level
o_spi_clk  out  1  SCK, idle low
o_cs_n  out  NUM_CH  per-channel chip select, active low, one-hot-low or all high
i_spi_miso  in  1  shared MISO
o_dv  out  1  one-cycle strobe: result outputs valid
o_ch  out  CH_W  channel of current result
o_temp  out  12  temperature, 0.25 °C/LSB (frame[14:3])
o_open  out  1  thermocouple open (frame[2])
o_bus_err  out  1  frame[15] or frame[1] set (dummy/ID bit nonzero; MISO stuck high)
o_frame  out  16  raw frame
o_busy  out  1  high from CS assertion through PUBLISH

Behaviour:
- Reset (async): all o_cs_n=1, o_spi_clk=0, o_dv=0, o_ch=0, o_temp=0, o_open=0, o_bus_err=0, o_frame=0, o_busy=0, FSM=IDLE, channel index=0, period timer=0.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, PUBLISH, NEXT, WAIT_PERIOD.
- IDLE: when i_enable=1, start the period timer at 0, select channel 0, drive its o_cs_n low, and go to CS_SETUP.
- CS_SETUP: wait CS_SETUP_CLKS cycles, then go to SHIFT.
- SHIFT: 16 SCK periods. SCK is high for CLKS_PER_HALF_BIT cycles, then low for CLKS_PER_HALF_BIT cycles.
  - MISO is sampled into the shift register MSB first, in the cycle SCK is driven high.
  - After the 16th low half, SCK stays low; go to CS_HOLD.
  - Frame time = CS_SETUP_CLKS + 32*CLKS_PER_HALF_BIT cycles.
- CS_HOLD: deassert that channel's o_cs_n for one cycle, then go to PUBLISH.
- PUBLISH: for one cycle, o_dv=1 and o_ch/o_temp/o_open/o_bus_err/o_frame are updated. These outputs hold until the next PUBLISH.
- NEXT:
  - If the channel is not the last, increment the channel and wait CS_SETUP_CLKS cycles with all CS high (enforced min CS-high time). Then assert the next CS and go to CS_SETUP.
  - If the channel is the last, wrap to 0 and go to WAIT_PERIOD.
- WAIT_PERIOD:
  - The period timer runs continuously from sweep start, saturating at SAMPLE_PERIOD_CLKS-1.
  - When the timer reaches SAMPLE_PERIOD_CLKS-1: if i_enable=1, restart the timer and begin the next sweep; else go to IDLE.
  - If a sweep lasts longer than the period, the next sweep starts immediately after NEXT. No overlap, no dropped channels.
- i_enable deasserted mid-sweep: the current frame and the remaining channels of the sweep complete, then the FSM goes to IDLE. Partial frames never occur.
- Reset mid-frame: CS rises and SCK falls immediately (async). No o_dv is produced for the aborted frame.
- At most one o_cs_n is low at any time. o_spi_clk toggles only while a CS is low.

Optional Feature:
Macro MAX6675_FAULT_HOLD_EN.
- Defined: a per-channel 12-bit last-good register (reset 0) is kept.
  - On PUBLISH with o_open=0 and o_bus_err=0, the register updates and o_temp = new value.
  - On a faulted frame, o_temp = that channel's last-good value; o_frame still shows the raw frame and the flags are still reported.
- Undefined: o_temp = frame[14:3] always; no per-channel storage.

Test Plan:
- NUM_CH=1, model returns 0x0C80 -> o_dv once per frame, o_temp=0x190 (100.00 °C), o_open=0, o_bus_err=0. Measure 32 SCK edges at a 26-clk period and first rise 10 clks after CS low.
- NUM_CH=4, channels return 0x0320/0x0640/0x0960/0x0C80 -> o_ch 0,1,2,3 in order, o_temp 0x064/0x0C8/0x12C/0x190. Next sweep starts exactly SAMPLE_PERIOD_CLKS (test value 5000) after the first, and only one CS is low at a time.
- Channel 2 returns 0x0004 -> o_open=1. With MAX6675_FAULT_HOLD_EN, o_temp equals channel 2's previous good value. Without it, o_temp=0.
- MISO tied high -> o_frame=0xFFFF, o_bus_err=1, o_open=1.
- Drop i_enable during channel 1's SHIFT -> channels 1..3 complete with 3 further o_dv pulses, then IDLE with all CS high and o_busy=0.
- Assert i_reset during bit 7 of SHIFT -> o_cs_n all 1 and SCK 0 in the same cycle, no o_dv. After release with i_enable=1, the scan restarts at channel 0.
